// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter.
// The producer drives tx_data/tx_valid. The transmitter drives tx_ready.
// A byte moves on a rising clock edge where tx_valid && tx_ready.
interface uart_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO in front of an 8N1 serialiser (LSB first) driving RsTx.
// Bits are timed by a baud counter of CLK_FREQ/BAUD_RATE cycles per bit.
// Optional feature: define UART_TX_PARITY_EN to add an even-parity bit after the data bits.
// The parity bit is computed when the byte is loaded.
// FIFO_DEPTH must be a power of two and at least 2. STOP_BITS must be 1 or 2.
module uart_tx #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    uart_tx_if.slave                    tx_if,
    output logic                        RsTx,
    output logic                        tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int unsigned STOP_CLKS    = STOP_BITS * CLKS_PER_BIT;
    localparam int unsigned CNT_W        = (STOP_CLKS > 1) ? $clog2(STOP_CLKS) : 1;
    localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_FIFO_W   = PTR_W + 1;

    localparam logic [CNT_W-1:0]      BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]      STOP_LAST = CNT_W'(STOP_CLKS - 1);
    localparam logic [CNT_FIFO_W-1:0] FIFO_FULL = CNT_FIFO_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_TX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    // ------------------------------------------------------------------
    // Byte FIFO
    // ------------------------------------------------------------------
    logic [7:0]            r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_FIFO_W-1:0] r_count;

    logic       w_push;
    logic       w_pop;
    logic       w_ready;
    logic [7:0] w_head;

    assign w_ready = (r_count != FIFO_FULL);
    assign w_push  = tx_if.tx_valid && w_ready;
    assign w_head  = r_mem[r_rd_ptr];

    // Storage array: left unreset, because the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_if.tx_data;
        end
    end

    // Pointers and occupancy. Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Serialiser FSM
    // ------------------------------------------------------------------
    state_e           r_state;
    logic [CNT_W-1:0] r_baud_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_tx;

    state_e           w_state_next;
    logic [CNT_W-1:0] w_baud_next;
    logic [2:0]       w_bit_next;
    logic [7:0]       w_shift_next;
    logic             w_tx_next;

`ifdef UART_TX_PARITY_EN
    logic r_parity;
    logic w_parity_next;
`endif

    // State register. The line is also registered here, so RsTx is glitch-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= StIdle;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_next;
            r_baud_cnt <= w_baud_next;
            r_bit_idx  <= w_bit_next;
            r_shift    <= w_shift_next;
            r_tx       <= w_tx_next;
`ifdef UART_TX_PARITY_EN
            r_parity   <= w_parity_next;
`endif
        end
    end

    // Next-state logic and FIFO pop. A byte is loaded from IDLE, or straight from the end of STOP.
    always_comb begin
        w_state_next  = r_state;
        w_baud_next   = r_baud_cnt;
        w_bit_next    = r_bit_idx;
        w_shift_next  = r_shift;
        w_tx_next     = r_tx;
        w_pop         = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_parity_next = r_parity;
`endif

        unique case (r_state)
            StIdle: begin
                w_tx_next   = 1'b1;
                w_baud_next = '0;
                w_bit_next  = '0;
                if (r_count != '0) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_head;
                    w_tx_next    = 1'b0;
                    w_state_next = StStart;
`ifdef UART_TX_PARITY_EN
                    w_parity_next = ^w_head;
`endif
                end
            end

            StStart: begin
                if (r_baud_cnt == BIT_LAST) begin
                    w_baud_next  = '0;
                    w_bit_next   = '0;
                    w_tx_next    = r_shift[0];
                    w_state_next = StData;
                end else begin
                    w_baud_next = r_baud_cnt + 1'b1;
                end
            end

            StData: begin
                if (r_baud_cnt == BIT_LAST) begin
                    w_baud_next = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_bit_next = '0;
`ifdef UART_TX_PARITY_EN
                        w_tx_next    = r_parity;
                        w_state_next = StParity;
`else
                        w_tx_next    = 1'b1;
                        w_state_next = StStop;
`endif
                    end else begin
                        // The next bit to drive sits one place above the current LSB.
                        w_bit_next   = r_bit_idx + 1'b1;
                        w_shift_next = {1'b0, r_shift[7:1]};
                        w_tx_next    = r_shift[1];
                    end
                end else begin
                    w_baud_next = r_baud_cnt + 1'b1;
                end
            end

`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (r_baud_cnt == BIT_LAST) begin
                    w_baud_next  = '0;
                    w_tx_next    = 1'b1;
                    w_state_next = StStop;
                end else begin
                    w_baud_next = r_baud_cnt + 1'b1;
                end
            end
`endif

            StStop: begin
                // One count covers all stop bits, so the line stays high for STOP_BITS periods.
                if (r_baud_cnt == STOP_LAST) begin
                    w_baud_next = '0;
                    w_bit_next  = '0;
                    if (r_count != '0) begin
                        w_pop        = 1'b1;
                        w_shift_next = w_head;
                        w_tx_next    = 1'b0;
                        w_state_next = StStart;
`ifdef UART_TX_PARITY_EN
                        w_parity_next = ^w_head;
`endif
                    end else begin
                        w_tx_next    = 1'b1;
                        w_state_next = StIdle;
                    end
                end else begin
                    w_baud_next = r_baud_cnt + 1'b1;
                end
            end

            default: begin
                w_tx_next    = 1'b1;
                w_baud_next  = '0;
                w_bit_next   = '0;
                w_state_next = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign tx_if.tx_ready = w_ready;
    assign RsTx           = r_tx;
    assign tx_busy        = (r_state != StIdle) || (r_count != '0);
    assign fifo_count     = r_count;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx. The baud rate is scaled down to 16 clocks per bit.
// A line monitor rebuilds every frame cycle by cycle.
// It compares each frame against bytes queued when the DUT accepted them.
module tb_uart_tx;
    localparam int unsigned CLK_FREQ   = 160;
    localparam int unsigned BAUD_RATE  = 10;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned STOP_BITS  = 1;
    localparam int          C          = 16;
`ifdef UART_TX_PARITY_EN
    localparam int          PAR        = 1;
`else
    localparam int          PAR        = 0;
`endif
    localparam int          NBITS      = 10 + STOP_BITS - 1 + PAR;
    localparam int          FRAME      = NBITS * C;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       RsTx;
    logic       tx_busy;
    logic [2:0] fifo_count;

    uart_tx_if u_if ();

    uart_tx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .FIFO_DEPTH (FIFO_DEPTH),
        .STOP_BITS  (STOP_BITS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_if      (u_if),
        .RsTx       (RsTx),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] sb_q[$];
    int         gap_q[$];
    logic       mon_busy = 1'b0;
    logic       mon_par  = 1'b0;

    // Expected line level for frame bit k of byte b.
    function automatic logic exp_level(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (PAR == 1 && k == 9) return ^b;
        return 1'b1;
    endfunction

    // Line monitor: starts on a low level, samples every cycle of the frame.
    // It abandons the frame if reset is asserted.
    initial begin : monitor
        int               gap;
        int               bad;
        logic             aborted;
        logic [7:0]       got_b;
        logic [7:0]       exp_b;
        logic [FRAME-1:0] samp;
        gap = 0;
        forever begin
            @(negedge clk);
            if (reset || RsTx !== 1'b0) begin
                gap++;
            end else begin
                mon_busy = 1'b1;
                aborted  = 1'b0;
                samp     = '0;
                samp[0]  = RsTx;
                for (int t = 1; t < FRAME; t++) begin
                    @(negedge clk);
                    if (reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    samp[t] = RsTx;
                end
                if (!aborted) begin
                    for (int k = 0; k < 8; k++) got_b[k] = samp[(k + 1) * C + C / 2];
                    mon_par = samp[9 * C + C / 2];
                    gap_q.push_back(gap);
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL frame_unexpected: got byte %02h, required no frame", got_b);
                    end else begin
                        exp_b = sb_q.pop_front();
                        if (got_b !== exp_b) begin
                            errors++;
                            $display("FAIL frame_byte: got %02h, required %02h", got_b, exp_b);
                        end
                        bad = 0;
                        for (int t = 0; t < FRAME; t++) begin
                            if (samp[t] !== exp_level(exp_b, t / C)) bad++;
                        end
                        checks++;
                        if (bad != 0) begin
                            errors++;
                            $display("FAIL frame_shape: %0d wrong cycles in frame of %02h, required 0",
                                     bad, exp_b);
                        end
                    end
                end
                gap      = 0;
                mon_busy = 1'b0;
            end
        end
    end

    // Waits (bounded) until nothing is queued, in flight or buffered.
    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !mon_busy && tx_busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int bad;
        u_if.tx_valid = 1'b0;
        u_if.tx_data  = 8'h00;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (RsTx !== 1'b1) begin
            errors++; $display("FAIL reset_rstx: got %b, required 1", RsTx);
        end
        checks++;
        if (tx_busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b, required 0", tx_busy);
        end
        checks++;
        if (fifo_count !== 3'd0) begin
            errors++; $display("FAIL reset_count: got %0d, required 0", fifo_count);
        end
        checks++;
        if (u_if.tx_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b, required 1", u_if.tx_ready);
        end
        bad = 0;
        repeat (2000) begin
            @(negedge clk);
            if (RsTx !== 1'b1 || tx_busy !== 1'b0 || fifo_count !== 3'd0
                || u_if.tx_ready !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL idle_quiet: %0d bad cycles, required 0", bad);
        end
    endtask

    task automatic test_single_byte();
        int len;
        bit ok;
        u_if.tx_data  = 8'h41;
        u_if.tx_valid = 1'b1;
        checks++;
        if (u_if.tx_ready !== 1'b1) begin
            errors++; $display("FAIL single_ready: got %b, required 1", u_if.tx_ready);
        end
        sb_q.push_back(8'h41);
        @(negedge clk);
        u_if.tx_valid = 1'b0;
        u_if.tx_data  = 8'hFF;
        checks++;
        if (RsTx !== 1'b1 || fifo_count !== 3'd1 || tx_busy !== 1'b1) begin
            errors++;
            $display("FAIL single_accept: got RsTx=%b count=%0d busy=%b, required 1 1 1",
                     RsTx, fifo_count, tx_busy);
        end
        @(negedge clk);
        checks++;
        if (RsTx !== 1'b0 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL single_latency: got RsTx=%b count=%0d, required 0 0", RsTx, fifo_count);
        end
        len = 0;
        while (tx_busy === 1'b1 && len < FRAME + 50) begin
            @(negedge clk);
            len++;
        end
        checks++;
        if (len != FRAME) begin
            errors++; $display("FAIL single_busy_len: got %0d cycles, required %0d", len, FRAME);
        end
        wait_idle(4 * FRAME, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL single_drain: got timeout, required idle");
        end
    endtask

    task automatic test_fifo_fill();
        logic [7:0] pat [6];
        int         w;
        int         gsum;
        bit         ok;
        pat = '{8'h41, 8'h42, 8'h31, 8'h30, 8'h55, 8'hAA};
        gap_q.delete();
        for (int i = 0; i < 6; i++) begin
            u_if.tx_data  = pat[i];
            u_if.tx_valid = 1'b1;
            checks++;
            if (u_if.tx_ready !== (i < 5)) begin
                errors++;
                $display("FAIL fill_ready[%0d]: got %b, required %b", i, u_if.tx_ready, (i < 5));
            end
            if (i < 5) sb_q.push_back(pat[i]);
            if (i == 5) begin
                checks++;
                if (fifo_count !== 3'd4) begin
                    errors++; $display("FAIL fill_count: got %0d, required 4", fifo_count);
                end
            end
            @(negedge clk);
        end
        w = 1;
        while (u_if.tx_ready !== 1'b1 && w < FRAME + 20) begin
            @(negedge clk);
            w++;
        end
        sb_q.push_back(8'hAA);
        @(negedge clk);
        u_if.tx_valid = 1'b0;
        checks++;
        if (w != FRAME - 3) begin
            errors++; $display("FAIL fill_late_accept: got wait %0d, required %0d", w, FRAME - 3);
        end
        wait_idle(8 * FRAME, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL fill_drain: got timeout, required idle");
        end
        gsum = 0;
        for (int i = 1; i < gap_q.size(); i++) gsum += gap_q[i];
        checks++;
        if (gap_q.size() != 6 || gsum != 0) begin
            errors++;
            $display("FAIL fill_no_gap: got %0d frames with gap sum %0d, required 6 and 0",
                     gap_q.size(), gsum);
        end
    endtask

    task automatic test_push_ignored();
        int bad;
        bit ok;
        logic [7:0] pat [5];
        pat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A};
        for (int i = 0; i < 5; i++) begin
            u_if.tx_data  = pat[i];
            u_if.tx_valid = 1'b1;
            checks++;
            if (u_if.tx_ready !== 1'b1) begin
                errors++; $display("FAIL ign_fill_ready[%0d]: got %b, required 1", i, u_if.tx_ready);
            end
            sb_q.push_back(pat[i]);
            @(negedge clk);
        end
        u_if.tx_data = 8'h99;
        bad = 0;
        repeat (20) begin
            if (u_if.tx_ready !== 1'b0 || fifo_count !== 3'd4) bad++;
            @(negedge clk);
        end
        u_if.tx_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL ign_full: %0d cycles not full, required 0", bad);
        end
        wait_idle(8 * FRAME, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL ign_drain: got timeout, required idle");
        end
    endtask

    task automatic test_reset_mid_frame();
        int w;
        int bad;
        bit ok;
        logic [7:0] pat [3];
        pat = '{8'h42, 8'h55, 8'h66};
        for (int i = 0; i < 3; i++) begin
            u_if.tx_data  = pat[i];
            u_if.tx_valid = 1'b1;
            sb_q.push_back(pat[i]);
            @(negedge clk);
        end
        u_if.tx_valid = 1'b0;
        w = 0;
        while (RsTx !== 1'b0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        repeat (4 * C + C / 2 - w + 2) @(negedge clk);
        checks++;
        if (RsTx !== 1'b0 || fifo_count !== 3'd2) begin
            errors++;
            $display("FAIL mid_pre_reset: got RsTx=%b count=%0d, required 0 2", RsTx, fifo_count);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (RsTx !== 1'b1 || fifo_count !== 3'd0 || tx_busy !== 1'b0 || u_if.tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: got RsTx=%b count=%0d busy=%b ready=%b, required 1 0 0 1",
                     RsTx, fifo_count, tx_busy, u_if.tx_ready);
        end
        sb_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        repeat (3 * C) begin
            @(negedge clk);
            if (RsTx !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL mid_flushed: %0d active cycles, required 0", bad);
        end
        u_if.tx_data  = 8'h31;
        u_if.tx_valid = 1'b1;
        sb_q.push_back(8'h31);
        @(negedge clk);
        u_if.tx_valid = 1'b0;
        wait_idle(4 * FRAME, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL mid_drain: got timeout, required idle");
        end
    endtask

    task automatic test_frame_parity();
        logic [7:0] pat [2];
        int         len;
        bit         ok;
        pat = '{8'h41, 8'h31};
        for (int i = 0; i < 2; i++) begin
            u_if.tx_data  = pat[i];
            u_if.tx_valid = 1'b1;
            sb_q.push_back(pat[i]);
            @(negedge clk);
            u_if.tx_valid = 1'b0;
            len = 0;
            while (tx_busy === 1'b1 && len < FRAME + 50) begin
                @(negedge clk);
                len++;
            end
            // Busy spans the accept cycle plus the whole frame.
            checks++;
            if (len != FRAME + 1) begin
                errors++;
                $display("FAIL frame_len[%0d]: got %0d cycles, required %0d", i, len, FRAME + 1);
            end
            wait_idle(4 * FRAME, ok);
            checks++;
            if (!ok) begin
                errors++; $display("FAIL frame_drain[%0d]: got timeout, required idle", i);
            end
`ifdef UART_TX_PARITY_EN
            checks++;
            if (mon_par !== ^pat[i]) begin
                errors++;
                $display("FAIL parity_bit[%0d]: got %b, required %b", i, mon_par, ^pat[i]);
            end
`endif
        end
    endtask

    initial begin
        u_if.tx_valid = 1'b0;
        u_if.tx_data  = 8'h00;
        test_reset();
        test_single_byte();
        test_fifo_fill();
        test_push_ignored();
        test_reset_mid_frame();
        test_frame_parity();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
